// File: rtl/hazard_ctrl_mc_pkg.sv
// hazard_pkg: shared encodings for the hazard controller
package hazard_pkg;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W = 2'b01;
  localparam logic [1:0] FWD_M = 2'b10;
  typedef enum logic [1:0] {MDU_IDLE, MDU_BUSY, MDU_DONE} mdu_state_t;
endpackage

// File: rtl/mdu_stall_fsm.sv
// mdu_stall_fsm: holds a multi-cycle mul/div in EX for MDU_LAT cycles
module mdu_stall_fsm
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic mdu_E,
  input  logic pc_sel,
  output logic mdu_start,
  output logic mdu_busy
);
  localparam int CW = MDU_LAT > 2 ? $clog2(MDU_LAT - 1) : 1;
  localparam logic [CW-1:0] LOAD = CW'(MDU_LAT > 1 ? MDU_LAT - 2 : 0);
  mdu_state_t state;
  logic [CW-1:0] cnt;
  assign mdu_start = !rst && state == MDU_IDLE && mdu_E && !pc_sel;
  assign mdu_busy = mdu_start || (!rst && state == MDU_BUSY);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MDU_IDLE;
      cnt <= '0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (mdu_E && !pc_sel) state <= MDU_LAT == 1 ? MDU_DONE : MDU_BUSY;
          cnt <= LOAD;
        end
        MDU_BUSY: begin
          if (cnt == '0) state <= MDU_DONE;
          cnt <= cnt - CW'(1);
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: forwarding, load-use/MDU stalls, redirect flushes and perf counters
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [1:0]        wbsel_E,
  input  logic              pc_sel,
  input  logic              mdu_E,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  input  logic [REG_AW-1:0] Rs1_E,
  input  logic [REG_AW-1:0] Rs2_E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [REG_AW-1:0] RD_M,
  input  logic [REG_AW-1:0] RD_W,
  input  logic              rs1_used_D,
  input  logic              rs2_used_D,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              mdu_start,
  output logic              mdu_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  logic lwstall, redirect, mstall, lstall;
  logic [CNT_W-1:0] sc_q, fc_q;
  mdu_stall_fsm #(.MDU_LAT(MDU_LAT)) u_fsm (
    .clk(clk),
    .rst(rst),
    .mdu_E(mdu_E),
    .pc_sel(pc_sel),
    .mdu_start(mdu_start),
    .mdu_busy(mdu_busy)
  );
  assign ForwardAE = rst ? FWD_RF
                   : (RegWriteM && RD_M == Rs1_E && Rs1_E != '0) ? FWD_M
                   : (RegWriteW && RD_W == Rs1_E && Rs1_E != '0) ? FWD_W : FWD_RF;
  assign ForwardBE = rst ? FWD_RF
                   : (RegWriteM && RD_M == Rs2_E && Rs2_E != '0) ? FWD_M
                   : (RegWriteW && RD_W == Rs2_E && Rs2_E != '0) ? FWD_W : FWD_RF;
  assign lwstall = wbsel_E == WB_MEM && RegWriteE && RD_E != '0 &&
                   ((rs1_used_D && Rs1_D == RD_E) || (rs2_used_D && Rs2_D == RD_E));
  assign redirect = !rst && pc_sel;
  assign mstall = !rst && !pc_sel && mdu_busy;
  assign lstall = !rst && !pc_sel && !mdu_busy && lwstall;
  assign stallF = mstall || lstall;
  assign stallD = mstall || lstall;
  assign stallE = mstall;
  assign flushD = redirect;
  assign flushE = redirect || lstall;
  assign flushM = mstall;
  assign stall_cnt = rst ? '0 : sc_q;
  assign flush_cnt = rst ? '0 : fc_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q <= '0;
      fc_q <= '0;
    end else begin
      sc_q <= sc_q + CNT_W'(stallF && !(&sc_q));
      fc_q <= fc_q + CNT_W'(pc_sel && !(&fc_q));
    end
  end
endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// tb_hazard_ctrl_mc: scoreboard bench for hazard_ctrl_mc with directed vectors
module tb_hazard_ctrl_mc;
  logic clk = 0, rst;
  logic RegWriteE, RegWriteM, RegWriteW, pc_sel, mdu_E, rs1_used_D, rs2_used_D;
  logic [1:0] wbsel_E;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
  logic [1:0] ForwardAE, ForwardBE;
  logic stallF, stallD, stallE, flushD, flushE, flushM, mdu_start, mdu_busy;
  logic [3:0] stall_cnt, flush_cnt;
  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic [2:0] st;
    logic [2:0] fl;
    logic start;
    logic busy;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;
  exp_t eq[$];
  string nq[$];
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  hazard_ctrl_mc #(.REG_AW(5), .MDU_LAT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .wbsel_E(wbsel_E), .pc_sel(pc_sel), .mdu_E(mdu_E),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
    .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .mdu_start(mdu_start), .mdu_busy(mdu_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [1:0] fa, input logic [1:0] fb,
                     input logic [2:0] st, input logic [2:0] fl, input logic start,
                     input logic busy, input logic [3:0] sc, input logic [3:0] fc);
    eq.push_back('{fa, fb, st, fl, start, busy, sc, fc});
    nq.push_back(n);
  endtask
  always @(negedge clk) begin
    if (eq.size() > 0) begin
      exp_t e, a;
      string n;
      e = eq.pop_front();
      n = nq.pop_front();
      a = '{ForwardAE, ForwardBE, {stallF, stallD, stallE}, {flushD, flushE, flushM},
            mdu_start, mdu_busy, stall_cnt, flush_cnt};
      total++;
      if (a === e) passed++;
      else $display("FAIL %s: got fa=%b fb=%b st=%b fl=%b start=%b busy=%b sc=%0d fc=%0d, want fa=%b fb=%b st=%b fl=%b start=%b busy=%b sc=%0d fc=%0d",
                    n, a.fa, a.fb, a.st, a.fl, a.start, a.busy, a.sc, a.fc,
                    e.fa, e.fb, e.st, e.fl, e.start, e.busy, e.sc, e.fc);
    end
  end
  initial begin
    {RegWriteE, RegWriteM, RegWriteW, pc_sel, mdu_E, rs1_used_D, rs2_used_D} = '0;
    wbsel_E = 0;
    {Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W} = '0;
    rst = 1;
    tick();
    tick();
    RegWriteM = 1; RD_M = 5; Rs1_E = 5; mdu_E = 1;
    chk("reset", 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0);
    tick();
    rst = 0; mdu_E = 0; RegWriteW = 1; RD_W = 5;
    chk("fwdA_M", 2'b10, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0);
    tick();
    RegWriteM = 0;
    chk("fwdA_W", 2'b01, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0);
    tick();
    RegWriteM = 1; Rs1_E = 0; Rs2_E = 5;
    chk("fwdA_x0_fwdB_M", 2'b00, 2'b10, 3'b000, 3'b000, 0, 0, 0, 0);
    tick();
    RegWriteM = 0; RD_W = 9; Rs2_E = 9;
    chk("fwdB_W", 2'b00, 2'b01, 3'b000, 3'b000, 0, 0, 0, 0);
    tick();
    RegWriteW = 0; Rs2_E = 0;
    wbsel_E = 2'b01; RegWriteE = 1; RD_E = 7; Rs2_D = 7; rs2_used_D = 1;
    chk("loaduse_rs2", 2'b00, 2'b00, 3'b110, 3'b010, 0, 0, 0, 0);
    tick();
    rs2_used_D = 0;
    chk("loaduse_unused", 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 1, 0);
    tick();
    rs1_used_D = 1; Rs1_D = 0; RD_E = 0;
    chk("loaduse_x0", 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 1, 0);
    tick();
    RD_E = 7; Rs1_D = 7; wbsel_E = 2'b00;
    chk("nonload", 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 1, 0);
    tick();
    wbsel_E = 2'b01; pc_sel = 1; mdu_E = 1;
    chk("redirect_wins", 2'b00, 2'b00, 3'b000, 3'b110, 0, 0, 1, 0);
    tick();
    pc_sel = 0; mdu_E = 0; RegWriteE = 0;
    chk("idle_after_redirect", 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 1, 1);
    tick();
    mdu_E = 1;
    chk("mdu_c1", 2'b00, 2'b00, 3'b111, 3'b001, 1, 1, 1, 1);
    tick();
    RegWriteE = 1;
    chk("mdu_c2_lw_masked", 2'b00, 2'b00, 3'b111, 3'b001, 0, 1, 2, 1);
    tick();
    chk("mdu_c3", 2'b00, 2'b00, 3'b111, 3'b001, 0, 1, 3, 1);
    tick();
    chk("mdu_c4", 2'b00, 2'b00, 3'b111, 3'b001, 0, 1, 4, 1);
    tick();
    RegWriteE = 0;
    chk("mdu_done", 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 5, 1);
    tick();
    mdu_E = 0;
    chk("mdu_idle", 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 5, 1);
    tick();
    mdu_E = 1;
    chk("mdu2_c1", 2'b00, 2'b00, 3'b111, 3'b001, 1, 1, 5, 1);
    tick();
    rst = 1;
    chk("rst_in_busy", 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0);
    tick();
    rst = 0; mdu_E = 0;
    chk("after_rst", 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 0, 0);
    tick();
    mdu_E = 1;
    chk("mdu3_c1", 2'b00, 2'b00, 3'b111, 3'b001, 1, 1, 0, 0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("mdu3_busy", 2'b00, 2'b00, 3'b111, 3'b001, 0, 1, 4'(k), 0);
    end
    tick();
    chk("mdu3_done_held", 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 4, 0);
    for (int k = 0; k < 20; k++) begin
      tick();
      mdu_E = 0; RegWriteE = 1;
      chk("sat_stall", 2'b00, 2'b00, 3'b110, 3'b010, 0, 0, (4 + k > 15) ? 4'd15 : 4'(4 + k), 0);
    end
    tick();
    RegWriteE = 0;
    chk("sat_held", 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 15, 0);
    for (int k = 0; k < 10 && eq.size() > 0; k++) tick();
    if (eq.size() > 0) begin
      total++;
      $display("FAIL drain: got %0d pending, want 0", eq.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_mc.md
# hazard_ctrl_mc

Parametrised pipeline hazard controller for the 5-stage RISC-V core, sitting beside the ID/EX/MEM/WB pipeline registers.
- Generates EX-stage operand forwarding selects, load-use stalls that ignore unused source fields, and branch/jump flushes.
- Stalls the pipeline for a multi-cycle multiply/divide unit (MDU) in EX via a small FSM.
- Keeps saturating stall and redirect performance counters.

## Interface
Parameters:
- REG_AW, 5, register-address width
- MDU_LAT, 4, EX cycles the MDU needs before its result is valid (≥1)
- CNT_W, 32, performance-counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- RegWriteE, RegWriteM, RegWriteW  in  1 each  register write enable of the instruction in E, M and W
- wbsel_E  in  2  writeback select of the instruction in E; WB_MEM (2'b01) marks a load
- pc_sel  in  1  redirect (taken branch/jump) resolved in E
- mdu_E  in  1  instruction in E is a multi-cycle mul/div
- Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W  in  REG_AW each  source and destination register addresses
- rs1_used_D, rs2_used_D  in  1 each  D instruction actually reads Rs1/Rs2
- ForwardAE, ForwardBE  out  2 each  operand select: 00 register file, 01 from W, 10 from M
- stallF, stallD, stallE  out  1 each  active-high hold of PC, IF/ID and ID/EX registers
- flushD, flushE, flushM  out  1 each  active-high bubble insert into IF/ID, ID/EX and EX/MEM
- mdu_start  out  1  single-cycle start pulse to the MDU
- mdu_busy  out  1  MDU stall in effect this cycle
- stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters

## Operation
- Forwarding, per operand:
  - Select 10 if RegWriteM, RD_M==Rs_E and Rs_E≠0.
  - Otherwise select 01 if RegWriteW, RD_W==Rs_E and Rs_E≠0.
  - Otherwise 00. M has priority over W.
- Load-use condition (lwstall): wbsel_E==WB_MEM, RegWriteE, RD_E≠0, and either (rs1_used_D and Rs1_D==RD_E) or (rs2_used_D and Rs2_D==RD_E).
- MDU FSM states:
  - IDLE: if mdu_E and not pc_sel, pulse mdu_start and go to BUSY. If MDU_LAT==1, go directly to DONE.
  - BUSY: load counter with MDU_LAT-2 on entry, decrement each cycle, go to DONE when the counter is 0.
  - DONE: no stall, so the instruction leaves E. Next state is IDLE.
- MDU stall condition (mdu_busy): (IDLE and mdu_E and not pc_sel) or state BUSY.
- Output priority, highest first:
  1. rst: all outputs 0.
  2. pc_sel: flushD=flushE=1, all stalls 0.
  3. mdu_busy: stallF=stallD=stallE=1, flushM=1.
  4. lwstall: stallF=stallD=1, flushE=1.
  5. Otherwise all stall/flush outputs 0.
- Forward selects are computed every cycle regardless of stall or flush; they are 00 only during rst.
- stall_cnt increments on every cycle with stallF=1. flush_cnt increments on every cycle with pc_sel=1 and rst=0. Both counters saturate at all-ones.

## Timing
- All stall, flush and forward outputs are combinational from the current inputs and FSM state; there is no added latency.
- MDU instruction occupancy in E is MDU_LAT+1 cycles: MDU_LAT cycles stalled, then one DONE cycle in which it advances.
- mdu_start is asserted exactly once per MDU instruction, in its first E cycle. mdu_E held high while in DONE does not restart the FSM.
- Reset values: FSM IDLE, counter 0, stall_cnt=flush_cnt=0, all outputs 0.
- Reset asserted mid-BUSY: FSM is IDLE after the edge, with no mdu_start and no stall.
- pc_sel and mdu_E both high in IDLE: the redirect wins and the MDU does not start.
- lwstall is masked while mdu_busy is asserted.
- Counter saturation at all-ones: the counter holds the value with no wrap.

## Structure
- Package hazard_pkg holds:
  - WB_MEM encoding
  - FWD_RF/FWD_W/FWD_M constants
  - FSM state encoding MDU_IDLE/MDU_BUSY/MDU_DONE
- Sub-module mdu_stall_fsm (parameter MDU_LAT) contains the FSM, latency counter, mdu_start and mdu_busy.
- The top level holds the forwarding logic, lwstall, priority muxing and performance counters.

## Test plan
- Forwarding: RD_M=RD_W=Rs1_E=5, RegWriteM=RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> 01. Rs1_E=0 -> 00.
- Load-use: load in E with RD_E=7; D with Rs2_D=7 and rs2_used_D=1 -> stallF=stallD=flushE=1, stall_cnt+1. Same with rs2_used_D=0 -> no stall.
- MDU with MDU_LAT=4: mdu_E held high -> mdu_start for 1 cycle; stallF/D/E and flushM high for 4 cycles; released in cycle 5; no second mdu_start.
- Redirect: pc_sel=1 with mdu_E=1 in IDLE -> flushD=flushE=1, mdu_start=0, flush_cnt+1.
- Reset in BUSY: rst pulsed in the 2nd stall cycle -> all outputs and counters 0 next cycle, FSM IDLE.
- Saturation with CNT_W=4: drive stallF for 20 cycles -> stall_cnt=15 and held.
